// File: rtl/div_iter_pkg.sv
// div_iter_pkg: ALU op codes, FSM states and helpers shared by the iterative divider
package div_iter_pkg;
   localparam logic [5:0] ALU_NOP  = 6'b000000;
   localparam logic [5:0] ALU_DIV  = 6'b011010;
   localparam logic [5:0] ALU_DIVU = 6'b011011;
   localparam logic [5:0] LAST_ITER = 6'd31;
   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
   function automatic logic [31:0] neg_if(input logic [31:0] v, input logic n);
      return n ? (~v + 32'd1) : v;
   endfunction
endpackage

// File: rtl/div_iter_if.sv
// div_iter_if: EX-stage operand/result/stall bundle between pipeline and divider
interface div_iter_if;
   logic        flush;
   logic [5:0]  ALUControl_i;
   logic [31:0] opdata1_i;
   logic [31:0] opdata2_i;
   logic [63:0] result_o;
   logic        stall_div;
   modport master (output flush, ALUControl_i, opdata1_i, opdata2_i, input result_o, stall_div);
   modport slave  (input flush, ALUControl_i, opdata1_i, opdata2_i, output result_o, stall_div);
endinterface

// File: rtl/div_iter_step.sv
// div_step: one radix-2 restoring division step on the partial remainder
module div_step (
   input  logic [32:0] rem_i,
   input  logic        msb_i,
   input  logic [31:0] dvs_i,
   output logic [32:0] rem_o,
   output logic        q_o
);
   logic [33:0] wide;
   logic [33:0] trial;
   // shift in the next dividend bit, then keep the trial difference only if it did not go negative
   always_comb begin
      wide  = {rem_i, msb_i};
      trial = wide - {2'b00, dvs_i};
      q_o   = ~trial[33];
      rem_o = q_o ? trial[32:0] : wide[32:0];
   end
endmodule

// File: rtl/div_iter.sv
// div_iter: 32-bit iterative DIV/DIVU with pipeline stall, result as {HI=rem, LO=quot}
module div_iter
   import div_iter_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input logic       clk,
   input logic       resetn,
   div_iter_if.slave bus
);
   state_t           state_q, state_d;
   logic [5:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0] dvd_q, dvd_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [WIDTH:0]   rem_q, rem_d;
   logic             qneg_q, qneg_d;
   logic             rneg_q, rneg_d;
   logic [63:0]      result_q, result_d;
   logic [32:0]      step_rem;
   logic             step_q;
   logic             is_div, s1, s2;

   div_step u_step (.rem_i(rem_q), .msb_i(dvd_q[WIDTH-1]), .dvs_i(dvs_q), .rem_o(step_rem), .q_o(step_q));

   assign is_div        = (bus.ALUControl_i == ALU_DIV) || (bus.ALUControl_i == ALU_DIVU);
   assign s1            = (bus.ALUControl_i == ALU_DIV) && bus.opdata1_i[31];
   assign s2            = (bus.ALUControl_i == ALU_DIV) && bus.opdata2_i[31];
   assign bus.stall_div = is_div && (state_q != DONE);
   assign bus.result_o  = result_q;

   // next-state: latch magnitudes in IDLE, one restoring step per BUSY cycle, sign fix on entry to DONE
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      dvd_d    = dvd_q;
      dvs_d    = dvs_q;
      rem_d    = rem_q;
      qneg_d   = qneg_q;
      rneg_d   = rneg_q;
      result_d = result_q;
      if (bus.flush) begin
         state_d  = IDLE;
         cnt_d    = 6'd0;
         result_d = 64'h0;
      end else begin
         case (state_q)
            IDLE: if (is_div) begin
               if (bus.opdata2_i == 32'h0) begin
                  state_d  = DONE;
                  result_d = {bus.opdata1_i, 32'hFFFF_FFFF};
               end else begin
                  state_d = BUSY;
                  dvd_d   = neg_if(bus.opdata1_i, s1);
                  dvs_d   = neg_if(bus.opdata2_i, s2);
                  qneg_d  = s1 ^ s2;
                  rneg_d  = s1;
                  rem_d   = '0;
                  cnt_d   = 6'd0;
               end
            end
            BUSY: begin
               rem_d = step_rem;
               dvd_d = {dvd_q[WIDTH-2:0], step_q};
               cnt_d = cnt_q + 6'd1;
               if (cnt_q == LAST_ITER) begin
                  state_d  = DONE;
                  result_d = {neg_if(step_rem[31:0], rneg_q), neg_if(dvd_d, qneg_q)};
               end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // state register with asynchronous active-low reset
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= IDLE;
         cnt_q    <= 6'd0;
         dvd_q    <= '0;
         dvs_q    <= '0;
         rem_q    <= '0;
         qneg_q   <= 1'b0;
         rneg_q   <= 1'b0;
         result_q <= 64'h0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         dvd_q    <= dvd_d;
         dvs_q    <= dvs_d;
         rem_q    <= rem_d;
         qneg_q   <= qneg_d;
         rneg_q   <= rneg_d;
         result_q <= result_d;
      end
   end
endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: directed vector bench for div_iter, checks stall window length and {HI, LO}
module tb_div_iter;
   import div_iter_pkg::*;

   typedef struct {
      logic [5:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] exp;
      int          stall;
      string       name;
   } vec_t;

   logic clk;
   logic resetn;
   int   checks;
   int   errors;
   vec_t vecs[9];

   div_iter_if bus ();
   div_iter dut (.clk(clk), .resetn(resetn), .bus(bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // drives one op starting in the current cycle, counts stall cycles up to the first non-stall cycle
   task automatic run(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [63:0] exp, input int exp_stall, input string nm);
      int  n;
      bit  done;
      n    = 0;
      done = 0;
      bus.ALUControl_i = op;
      bus.opdata1_i    = a;
      bus.opdata2_i    = b;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (!bus.stall_div) begin
            done = 1;
            break;
         end
         n++;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: stall still high after %0d cycles", nm, n);
      end
      chk({nm, "_stall"}, 64'(n), 64'(exp_stall));
      chk({nm, "_result"}, bus.result_o, exp);
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      vecs[0] = '{ALU_DIVU, 32'd7,          32'd2,          {32'h1,        32'h3},        33, "divu_7_2"};
      vecs[1] = '{ALU_DIV,  32'hFFFFFFF9,   32'd2,          {32'hFFFFFFFF, 32'hFFFFFFFD}, 33, "div_m7_2"};
      vecs[2] = '{ALU_DIV,  32'd7,          32'hFFFFFFFE,   {32'h1,        32'hFFFFFFFD}, 33, "div_7_m2"};
      vecs[3] = '{ALU_DIV,  32'h80000000,   32'hFFFFFFFF,   {32'h0,        32'h80000000}, 33, "div_min_m1"};
      vecs[4] = '{ALU_DIVU, 32'hFFFFFFFF,   32'd1,          {32'h0,        32'hFFFFFFFF}, 33, "divu_max_1"};
      vecs[5] = '{ALU_DIVU, 32'h80000000,   32'hFFFFFFFF,   {32'h80000000, 32'h0},        33, "divu_big_small"};
      vecs[6] = '{ALU_DIV,  32'hFFFFFF9C,   32'd7,          {32'hFFFFFFFE, 32'hFFFFFFF2}, 33, "div_m100_7"};
      vecs[7] = '{ALU_DIVU, 32'd100,        32'd0,          {32'd100,      32'hFFFFFFFF}, 1,  "divu_100_0"};
      vecs[8] = '{ALU_DIV,  32'hFFFFFFF9,   32'd0,          {32'hFFFFFFF9, 32'hFFFFFFFF}, 1,  "div_m7_0"};

      resetn = 1'b1;
      bus.flush = 1'b0;
      bus.ALUControl_i = ALU_NOP;
      bus.opdata1_i = 32'h0;
      bus.opdata2_i = 32'h0;
      #2 resetn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_result", bus.result_o, 64'h0);
      chk("reset_stall_nop", 64'(bus.stall_div), 64'h0);
      bus.ALUControl_i = ALU_DIVU;
      #1;
      chk("reset_stall_div", 64'(bus.stall_div), 64'h1);
      bus.ALUControl_i = ALU_NOP;
      @(posedge clk);
      #1;
      resetn = 1'b1;

      foreach (vecs[i]) run(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].stall, vecs[i].name);
      bus.ALUControl_i = ALU_NOP;
      @(negedge clk);
      chk("hold_result", bus.result_o, {32'hFFFFFFF9, 32'hFFFFFFFF});
      chk("hold_stall", 64'(bus.stall_div), 64'h0);

      @(posedge clk);
      #1;
      run(ALU_DIVU, 32'd20, 32'd6, {32'd2, 32'd3}, 33, "b2b_first");
      run(ALU_DIVU, 32'd15, 32'd4, {32'd3, 32'd3}, 33, "b2b_second");
      bus.ALUControl_i = ALU_NOP;

      @(posedge clk);
      #1;
      bus.ALUControl_i = ALU_DIV;
      bus.opdata1_i = 32'd1000;
      bus.opdata2_i = 32'd3;
      repeat (10) @(posedge clk);
      #1;
      chk("pre_flush_stall", 64'(bus.stall_div), 64'h1);
      bus.flush = 1'b1;
      @(posedge clk);
      #1;
      bus.flush = 1'b0;
      bus.ALUControl_i = ALU_NOP;
      @(negedge clk);
      chk("flush_result", bus.result_o, 64'h0);
      chk("flush_stall", 64'(bus.stall_div), 64'h0);
      @(posedge clk);
      #1;
      run(ALU_DIVU, 32'd9, 32'd3, {32'd0, 32'd3}, 33, "post_flush");
      bus.ALUControl_i = ALU_NOP;

      @(posedge clk);
      #1;
      bus.ALUControl_i = ALU_DIVU;
      bus.opdata1_i = 32'd20;
      bus.opdata2_i = 32'd6;
      repeat (5) @(posedge clk);
      #3;
      resetn = 1'b0;
      #1;
      chk("async_reset_result", bus.result_o, 64'h0);
      @(posedge clk);
      #1;
      chk("reset_hold_result", bus.result_o, 64'h0);
      resetn = 1'b1;
      run(ALU_DIVU, 32'd20, 32'd6, {32'd2, 32'd3}, 33, "post_reset");
      bus.ALUControl_i = ALU_NOP;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/div_iter.md
# div_iter

Iterative 32-bit integer divider for the EX stage of the MIPS core. It serves DIV and DIVU and mirrors the multiplier's stall interface. It holds the pipeline while one radix-2 restoring iteration runs per cycle. The quotient/remainder pair goes to the HI/LO write path in the same `{HI, LO}` layout as the multiply result.

## Interface
Parameters:
- `WIDTH`, 32, operand width; only 32 is supported.

Ports:
- `clk`  in  1  core clock; all state changes on rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous pipeline flush; aborts any division.
- `ALUControl_i`  in  6  EX-stage ALU op; `ALU_DIV` = signed, `ALU_DIVU` = unsigned, anything else = no division.
- `opdata1_i`  in  32  dividend (rs).
- `opdata2_i`  in  32  divisor (rt).
- `result_o`  out  64  `{remainder, quotient}`, i.e. `{HI, LO}`; registered.
- `stall_div`  out  1  pipeline stall request.

## Operation
- FSM states: IDLE, BUSY, DONE. Iteration counter `cnt` is 6 bits.
- **IDLE, op is DIV/DIVU, `flush` low:**
  - Latch magnitudes of both operands. Two's-complement negate each operand if the op is signed and its bit 31 is set.
  - Latch sign flags: quotient negative = sign1 XOR sign2 (signed only); remainder negative = sign1 (signed only).
  - Clear the partial remainder (33 bits) and set `cnt` = 0.
  - Go to BUSY.
- **IDLE, divisor == 0:** go directly to DONE with quotient = 32'hFFFFFFFF and remainder = `opdata1_i` unchanged, for both signed and unsigned ops. No sign fix is applied.
- **BUSY:** one restoring step per cycle.
  - Shift `{rem, dividend}` left by 1.
  - Trial = rem − divisor, computed in 33 bits.
  - If the trial is non-negative, rem = trial and the quotient bit is 1; otherwise the quotient bit is 0.
  - `cnt` increments. The step with `cnt` == 31 completes, then the FSM goes to DONE.
- **Entry to DONE:** apply the sign fix (negate quotient and/or remainder per the latched flags) and register `result_o`.
  - −2^31 / −1 yields quotient 32'h80000000 and remainder 0. This is natural wrap; no trap.
- **DONE:** go to IDLE unconditionally on the next edge.
- Operand inputs are ignored outside IDLE.
- `stall_div` is combinational: (`ALUControl_i` is DIV or DIVU) AND state != DONE.
- `ALUControl_i` may change to a non-div op during BUSY. Iteration still continues to DONE, and `stall_div` follows the combinational rule.

## Timing
- Reset values (async, `resetn` low): state IDLE, `cnt` 0, `result_o` 64'h0, all internal registers 0. `stall_div` is 0 whenever the op is not a division.
- Normal latency, with cycle 0 the first cycle the div op is presented in IDLE:
  - `stall_div` is high for cycles 0–32 (33 cycles).
  - Cycle 33 is DONE: `stall_div` low, `result_o` valid, the pipeline advances at the end of cycle 33.
- Divide-by-zero latency: `stall_div` is high for cycle 0 only; cycle 1 is DONE.
- Back-to-back divisions: after DONE→IDLE the next div op in EX starts in that IDLE cycle. There is no extra bubble beyond the DONE cycle.
- `flush` high at any edge:
  - Next state IDLE, `cnt` 0, `result_o` cleared to 0.
  - Flush has priority over every transition, including IDLE→BUSY and entry to DONE.
- `resetn` asserted mid-BUSY: the block returns immediately to its reset values. A div op held after release starts a fresh 33-cycle stall.
- `result_o` holds its value from DONE until the next DONE, flush or reset.

## Structure
- `ALU_DIV` and `ALU_DIVU` come from the shared `aludefines.vh`; no new global constants are needed.
- The state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2) and the last-iteration constant (31) are local parameters.
- One combinational sub-module, `div_step`:
  - Inputs: 33-bit rem, incoming dividend MSB, 32-bit divisor.
  - Outputs: next rem and quotient bit.
  - It is instantiated once and reused each cycle.

## Test plan
- DIVU 7 / 2 → `stall_div` high for exactly 33 cycles; on cycle 33 `result_o` = {32'h1, 32'h3}, stall low.
- DIV −7 (32'hFFFFFFF9) / 2 → `result_o` = {32'hFFFFFFFF, 32'hFFFFFFFD}. Also DIV 7 / −2 → {32'h1, 32'hFFFFFFFD}.
- DIV 32'h80000000 / 32'hFFFFFFFF → {32'h0, 32'h80000000}, no hang. Also DIVU 32'hFFFFFFFF / 1 → {0, 32'hFFFFFFFF}.
- DIVU 100 / 0 → stall for 1 cycle; on cycle 1 `result_o` = {32'd100, 32'hFFFFFFFF}.
- DIV 1000 / 3, with `flush` on BUSY cycle 10 → next cycle state IDLE, `result_o` = 0, stall low once the op is removed. A new DIVU 9 / 3 then gives {0, 3} after a full 33-cycle stall.
- Two back-to-back DIVU ops (20 / 6 then 15 / 4) → {2, 3} then {3, 3}, with stall windows of 33 cycles each separated by one DONE cycle. Separately, `resetn` pulsed low mid-BUSY → `result_o` 0 and state IDLE immediately, independent of `clk`.
